// File: rtl/pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_sequencer
//  Description : Carrier/compare PWM controller with soft-start, shadowed
//                duty updates, latched fault and dead-time gate pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_sequencer #(
  parameter int PERIOD = 100,
  parameter int CW     = 12,
  parameter int STEP   = 20,
  parameter int DEAD   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] duty_in,
  input  logic          fault_in,
  input  logic          clr_fault,
  output logic          pwm_h,
  output logic          pwm_l,
  output logic [CW-1:0] cmp_act,
  output logic [1:0]    state,
  output logic          period_tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [CW-1:0] c_period      = CW'(PERIOD);
  localparam logic [CW-1:0] c_period_last = CW'(PERIOD - 1);
  localparam logic [CW:0]   c_step        = (CW + 1)'(STEP);
  localparam logic [7:0]    c_dead        = 8'(DEAD);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_cmp_act;
  logic [1:0]    r_state;
  logic          r_raw;
  logic [7:0]    r_dt_cnt;

  logic          w_tick;
  logic          w_active;
  logic          w_raw_nxt;
  logic [CW-1:0] w_tgt;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_cmp_ramp;
  logic [CW-1:0] w_cmp_nxt;
  logic [1:0]    w_state_nxt;

  assign w_tick    = (r_cnt == c_period_last);
  assign w_tgt     = (duty_in > c_period) ? c_period : duty_in;
  assign w_active  = (r_state == S_RAMP) || (r_state == S_RUN);
  // One extra bit keeps the soft-start sum from wrapping near full scale
  assign w_sum     = {1'b0, r_cmp_act} + c_step;
  assign w_raw_nxt = w_active && (r_cnt < r_cmp_act);

  always_comb begin
    w_cmp_ramp = w_tgt;
    if (r_cmp_act < w_tgt) begin
      if (w_sum < {1'b0, w_tgt}) begin
        w_cmp_ramp = w_sum[CW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (fault_in) begin
      w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_FAULT: if (clr_fault && !en) w_state_nxt = S_IDLE;
        S_IDLE:  if (en) w_state_nxt = S_RAMP;
        S_RAMP: begin
          if (!en) begin
            w_state_nxt = S_IDLE;
          end else if (w_tick && (w_cmp_ramp == w_tgt)) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN:   if (!en) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Compare only moves at carrier boundaries, except for the forced zero
  always_comb begin
    w_cmp_nxt = r_cmp_act;
    if ((r_state == S_IDLE) || (r_state == S_FAULT) ||
        (w_state_nxt == S_IDLE) || (w_state_nxt == S_FAULT)) begin
      w_cmp_nxt = '0;
    end else if (w_tick) begin
      w_cmp_nxt = (r_state == S_RAMP) ? w_cmp_ramp : w_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cmp_act <= '0;
      r_state   <= S_IDLE;
      r_raw     <= 1'b0;
      r_dt_cnt  <= 8'd0;
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + 1'b1;
      r_cmp_act <= w_cmp_nxt;
      r_state   <= w_state_nxt;
      r_raw     <= w_raw_nxt;
      if (w_raw_nxt != r_raw) begin
        r_dt_cnt <= c_dead;
      end else if (r_dt_cnt != 8'd0) begin
        r_dt_cnt <= r_dt_cnt - 8'd1;
      end
    end
  end

  assign pwm_h       = w_active && r_raw && (r_dt_cnt == 8'd0);
  assign pwm_l       = w_active && !r_raw && (r_dt_cnt == 8'd0);
  assign cmp_act     = r_cmp_act;
  assign state       = r_state;
  assign period_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_sequencer
//  Description : Scoreboard bench for pwm_sequencer against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_sequencer;

  localparam int PERIOD = 100;
  localparam int CW     = 12;
  localparam int STEP   = 20;
  localparam int DEAD   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] duty_in;
  logic          fault_in;
  logic          clr_fault;
  logic          pwm_h;
  logic          pwm_l;
  logic [CW-1:0] cmp_act;
  logic [1:0]    state;
  logic          period_tick;

  pwm_sequencer #(.PERIOD(PERIOD), .CW(CW), .STEP(STEP), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .en(en), .duty_in(duty_in), .fault_in(fault_in),
    .clr_fault(clr_fault), .pwm_h(pwm_h), .pwm_l(pwm_l), .cmp_act(cmp_act),
    .state(state), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit h;
    bit l;
    int cmp;
    int st;
    bit tick;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: 0=IDLE 1=RAMP 2=RUN 3=FAULT; hist holds recent raw PWM levels
  int   m_state, m_cnt, m_cmp;
  bit   hist[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_cmp   = 0;
    hist.delete();
    for (int i = 0; i <= DEAD; i++) hist.push_back(1'b0);
  endtask

  // Gate follows raw PWM only once raw has been steady for DEAD+1 cycles
  task automatic model_step();
    int   tgt, nst, ncmp, ramp_cmp;
    bit   tick, act, nraw, stable, act2;
    exp_t e;
    tick     = (m_cnt == PERIOD - 1);
    tgt      = (int'(duty_in) > PERIOD) ? PERIOD : int'(duty_in);
    act      = (m_state == 1) || (m_state == 2);
    nraw     = act && (m_cnt < m_cmp);
    ramp_cmp = (m_cmp < tgt) ? (((m_cmp + STEP) < tgt) ? m_cmp + STEP : tgt) : tgt;
    nst      = m_state;
    if (fault_in) nst = 3;
    else begin
      case (m_state)
        3: if (clr_fault && !en) nst = 0;
        0: if (en) nst = 1;
        1: if (!en) nst = 0; else if (tick && ramp_cmp == tgt) nst = 2;
        default: if (!en) nst = 0;
      endcase
    end
    if (m_state == 0 || m_state == 3 || nst == 0 || nst == 3) ncmp = 0;
    else if (tick) ncmp = (m_state == 1) ? ramp_cmp : tgt;
    else ncmp = m_cmp;
    m_state = nst;
    m_cmp   = ncmp;
    m_cnt   = (m_cnt + 1) % PERIOD;
    hist.push_back(nraw);
    void'(hist.pop_front());
    stable = 1'b1;
    foreach (hist[i]) if (hist[i] != nraw) stable = 1'b0;
    act2   = (m_state == 1) || (m_state == 2);
    e.h    = act2 && nraw && stable;
    e.l    = act2 && !nraw && stable;
    e.cmp  = m_cmp;
    e.st   = m_state;
    e.tick = (m_cnt == PERIOD - 1);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pwm_h", int'(pwm_h), int'(e.h));
      check("pwm_l", int'(pwm_l), int'(e.l));
      check("cmp_act", int'(cmp_act), e.cmp);
      check("state", int'(state), e.st);
      check("period_tick", int'(period_tick), int'(e.tick));
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic run_count(input int n, output int hc, output int lc);
    hc = 0;
    lc = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      hc += int'(pwm_h);
      lc += int'(pwm_l);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm_h"}, int'(pwm_h), 0);
    check({tag, "_pwm_l"}, int'(pwm_l), 0);
    check({tag, "_cmp"}, int'(cmp_act), 0);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_tick"}, int'(period_tick), 0);
  endtask

  initial begin
    int hc, lc, guard;
    rst = 1'b1; en = 1'b0; duty_in = '0; fault_in = 1'b0; clr_fault = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (250) cycle();

    // Soft-start to 50 then steady-state widths
    en = 1'b1; duty_in = 12'd50;
    repeat (400) cycle();
    check("run_state", int'(state), 2);
    check("run_cmp", int'(cmp_act), 50);
    run_count(PERIOD, hc, lc);
    check("h_width_50", hc, 45);
    check("l_width_50", lc, 45);

    // Mid-period duty change
    guard = 0;
    while (m_cnt != 10 && guard < 200) begin cycle(); guard++; end
    duty_in = 12'd30;
    cycle();
    check("cmp_hold", int'(cmp_act), 50);
    repeat (300) cycle();
    run_count(PERIOD, hc, lc);
    check("h_width_30", hc, 25);
    check("l_width_30", lc, 65);

    // Fault latch and clear protocol
    fault_in = 1'b1; cycle(); fault_in = 1'b0;
    check("fault_h", int'(pwm_h), 0);
    check("fault_l", int'(pwm_l), 0);
    check("fault_state", int'(state), 3);
    clr_fault = 1'b1; repeat (3) cycle();
    check("fault_hold_en", int'(state), 3);
    fault_in = 1'b1; cycle();
    en = 1'b0; cycle();
    check("fault_hold_flt", int'(state), 3);
    fault_in = 1'b0; cycle();
    check("fault_clear", int'(state), 0);
    clr_fault = 1'b0;

    // Clamped target: full-on high side
    en = 1'b1; duty_in = 12'd150;
    repeat (800) cycle();
    check("clamp_cmp", int'(cmp_act), 100);
    run_count(PERIOD, hc, lc);
    check("h_full", hc, 100);
    check("l_full", lc, 0);

    // Asynchronous reset mid-ramp
    en = 1'b0; repeat (3) cycle();
    en = 1'b1; duty_in = 12'd80;
    guard = 0;
    while (!(m_state == 1 && m_cmp == 40) && guard < 1000) begin cycle(); guard++; end
    check("ramp_reached", int'(guard < 1000), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized operation
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 59) == 0) duty_in = CW'($urandom_range(0, 160));
      fault_in  = ($urandom_range(0, 399) == 0);
      clr_fault = ($urandom_range(0, 19) == 0);
      if (m_state == 3 && $urandom_range(0, 49) == 0) en = 1'b0;
      cycle();
    end

    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
